magnetron: RTL and testbench



---
 rtl/magnetron_pkg.sv | 18 +
 rtl/magnetron_sync_2ff.sv | 25 ++
 rtl/magnetron.sv | 60 ++++++
 tb/tb_magnetron.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/magnetron_pkg.sv
// Shared types and constants for the magnetron enable controller.
package magnetron_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      COOK = 1'b1
   } state_t;

   localparam int unsigned SYNC_STAGES = 2;

   // Inactive levels, used as synchronizer reset values
   localparam logic STARTN_RST     = 1'b1;
   localparam logic STOPN_RST      = 1'b1;
   localparam logic CLEARN_RST     = 1'b1;
   localparam logic DOORCLOSED_RST = 1'b0;
   localparam logic TIMERDONE_RST  = 1'b0;

endpackage

// File: rtl/magnetron_sync_2ff.sv
// Single-bit flop-chain synchronizer with a parameterized, synchronous active-low reset value.
module sync_2ff
   import magnetron_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sr <= {SYNC_STAGES{RST_VAL}};
      end else begin
         sr <= {sr[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/magnetron.sv
// Magnetron enable controller: start on a startn falling edge, stop on any kill condition.
// Define MAGNETRON_SYNC_EN to pass all inputs through 2-flop synchronizers.
module magnetron
   import magnetron_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic startn,
   input  logic stopn,
   input  logic clearn,
   input  logic doorclosed,
   input  logic timerdone,
   output logic mag_on
);

   logic s_startn;
   logic s_stopn;
   logic s_clearn;
   logic s_doorclosed;
   logic s_timerdone;

`ifdef MAGNETRON_SYNC_EN
   sync_2ff #(.RST_VAL(STARTN_RST))     u_sync_startn     (.clk(clk), .resetn(resetn), .d(startn),     .q(s_startn));
   sync_2ff #(.RST_VAL(STOPN_RST))      u_sync_stopn      (.clk(clk), .resetn(resetn), .d(stopn),      .q(s_stopn));
   sync_2ff #(.RST_VAL(CLEARN_RST))     u_sync_clearn     (.clk(clk), .resetn(resetn), .d(clearn),     .q(s_clearn));
   sync_2ff #(.RST_VAL(DOORCLOSED_RST)) u_sync_doorclosed (.clk(clk), .resetn(resetn), .d(doorclosed), .q(s_doorclosed));
   sync_2ff #(.RST_VAL(TIMERDONE_RST))  u_sync_timerdone  (.clk(clk), .resetn(resetn), .d(timerdone),  .q(s_timerdone));
`else
   assign s_startn     = startn;
   assign s_stopn      = stopn;
   assign s_clearn     = clearn;
   assign s_doorclosed = doorclosed;
   assign s_timerdone  = timerdone;
`endif

   state_t state;
   logic   startn_q;
   logic   start_ev;
   logic   kill;

   assign start_ev = startn_q & ~s_startn;
   assign kill     = ~s_stopn | ~s_clearn | ~s_doorclosed | s_timerdone;

   // startn_q resets low so a button held through reset is not seen as a press
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         startn_q <= 1'b0;
      end else begin
         startn_q <= s_startn;
         unique case (state)
            IDLE: if (start_ev && !kill) state <= COOK;
            COOK: if (kill)              state <= IDLE;
         endcase
      end
   end

   assign mag_on = (state == COOK);

endmodule

// File: tb/tb_magnetron.sv
// Directed and random-soak bench for magnetron; honours MAGNETRON_SYNC_EN.
module tb_magnetron;

`ifdef MAGNETRON_SYNC_EN
   localparam int EXTRA = 2;
`else
   localparam int EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic resetn, startn, stopn, clearn, doorclosed, timerdone;
   logic mag_on;

   int n_checks = 0;
   int n_fail   = 0;

   magnetron dut (
      .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn),
      .clearn(clearn), .doorclosed(doorclosed), .timerdone(timerdone),
      .mag_on(mag_on)
   );

   always #5 clk = ~clk;

   // Reference model; inputs packed as {startn, stopn, clearn, doorclosed, timerdone}
   localparam logic [4:0] IN_RST = 5'b11100;
   logic [4:0] m_s1 = IN_RST, m_s2 = IN_RST;
   logic       m_st = 1'b0, m_prev = 1'b0;
   logic [4:0] m_in, m_eff;

   assign m_in = {startn, stopn, clearn, doorclosed, timerdone};
`ifdef MAGNETRON_SYNC_EN
   assign m_eff = m_s2;
`else
   assign m_eff = m_in;
`endif

   function automatic logic model_next(input logic st, input logic prev, input logic [4:0] e);
      logic kill;
      kill = ~e[3] | ~e[2] | ~e[1] | e[0];
      if (kill)          return 1'b0;
      if (st)            return 1'b1;
      return prev & ~e[4];
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         m_st   <= 1'b0;
         m_prev <= 1'b0;
         m_s1   <= IN_RST;
         m_s2   <= IN_RST;
      end else begin
         m_st   <= model_next(m_st, m_prev, m_eff);
         m_prev <= m_eff[4];
         m_s1   <= m_in;
         m_s2   <= m_s1;
      end
   end

   task automatic check_eq(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: mag_on=%0b expected %0b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      startn = 1'b1; stopn = 1'b1; clearn = 1'b1; doorclosed = 1'b1; timerdone = 1'b0;
   endtask

   initial begin
      // Reset with random inputs
      resetn = 1'b0;
      startn = 1'($urandom); stopn = 1'($urandom); clearn = 1'($urandom);
      doorclosed = 1'($urandom); timerdone = 1'($urandom);
      #2;
      tick(2);
      check_eq("reset", mag_on, 1'b0);

`ifndef MAGNETRON_SYNC_EN
      // Button held through reset must not start cooking
      idle_inputs();
      startn = 1'b0;
      resetn = 1'b1;
      tick(3);
      check_eq("held_through_reset", mag_on, 1'b0);
      startn = 1'b1; tick(1);
      startn = 1'b0; tick(1);
      check_eq("repress_after_reset", mag_on, 1'b1);
      stopn = 1'b0; tick(1); stopn = 1'b1;
      check_eq("stop_after_repress", mag_on, 1'b0);
`else
      idle_inputs();
      resetn = 1'b1;
      tick(4);
      check_eq("idle_after_reset", mag_on, 1'b0);
`endif

      // Normal cook with exact start latency, then one-cycle timer pulse
      idle_inputs(); tick(3);
      startn = 1'b0;
      tick(EXTRA);
      check_eq("start_not_early", mag_on, 1'b0);
      tick(1);
      check_eq("start", mag_on, 1'b1);
      tick(2);
      check_eq("cook_hold", mag_on, 1'b1);
      timerdone = 1'b1; tick(1); timerdone = 1'b0;
      tick(EXTRA);
      check_eq("timer_stop", mag_on, 1'b0);
      tick(3);
      check_eq("timer_stays_off", mag_on, 1'b0);

      // Door interlock
      startn = 1'b1; tick(3);
      doorclosed = 1'b0; tick(3);
      startn = 1'b0; tick(EXTRA + 1);
      check_eq("door_open_start", mag_on, 1'b0);
      tick(2);
      doorclosed = 1'b1; tick(EXTRA + 3);
      check_eq("door_close_no_press", mag_on, 1'b0);
      startn = 1'b1; tick(EXTRA + 1);
      startn = 1'b0; tick(EXTRA + 1);
      check_eq("door_closed_press", mag_on, 1'b1);
      doorclosed = 1'b0; tick(EXTRA + 1);
      check_eq("door_open_cook", mag_on, 1'b0);
      doorclosed = 1'b1;

      // Stop and clear pulses while cooking
      startn = 1'b1; tick(EXTRA + 2);
      startn = 1'b0; tick(EXTRA + 1);
      check_eq("restart_stop", mag_on, 1'b1);
      stopn = 1'b0; tick(1); stopn = 1'b1;
      tick(EXTRA);
      check_eq("stop_pulse", mag_on, 1'b0);
      startn = 1'b1; tick(EXTRA + 2);
      startn = 1'b0; tick(EXTRA + 1);
      check_eq("restart_clear", mag_on, 1'b1);
      clearn = 1'b0; tick(1); clearn = 1'b1;
      tick(EXTRA);
      check_eq("clear_pulse", mag_on, 1'b0);

      // Start edge coincident with a kill is discarded
      startn = 1'b1; tick(EXTRA + 2);
      startn = 1'b0; stopn = 1'b0; tick(1); stopn = 1'b1;
      tick(EXTRA + 3);
      check_eq("start_with_stop", mag_on, 1'b0);
      startn = 1'b1; tick(EXTRA + 2);
      startn = 1'b0; timerdone = 1'b1; tick(1); timerdone = 1'b0;
      tick(EXTRA + 3);
      check_eq("start_with_timer", mag_on, 1'b0);

      // Random soak against the model
      for (int c = 0; c < 3000; c++) begin
         startn     = ~startn;
         stopn      = ($urandom_range(0, 15) != 0);
         clearn     = ($urandom_range(0, 31) != 0);
         doorclosed = ($urandom_range(0, 15) != 0);
         timerdone  = ($urandom_range(0, 15) == 0);
         resetn     = ($urandom_range(0, 199) != 0);
         tick(1);
         check_eq("soak", mag_on, m_st);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
